// File: rtl/fabric_out_pkg.sv
// Shared definitions for the fabric-port-out flit path: lane bit layout, framing states, flit record.
package fabric_out_pkg;

  // Lane control bits sit at FLIT_WIDTH - <offset>
  localparam int unsigned LANE_VALID_BIT     = 1;
  localparam int unsigned LANE_HEAD_BIT      = 2;
  localparam int unsigned LANE_TAIL_BIT      = 3;
  localparam int unsigned LANE_CTRL_BITS     = 3;
  localparam int unsigned FLIT_PAYLOAD_MAX_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } frame_state_t;

  typedef struct packed {
    logic [FLIT_PAYLOAD_MAX_W-1:0] payload;
    logic                          head;
    logic                          tail;
  } flit_t;

endpackage

// File: rtl/fabric_out_lane_select.sv
// Lowest-set-bit picker: one-hot and binary index of the lowest set bit of a lane mask.
module fabric_out_lane_select #(
  parameter int unsigned NUM_FLITS = 4,
  parameter int unsigned IDX_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1
) (
  input  logic [NUM_FLITS-1:0] mask,
  output logic [NUM_FLITS-1:0] onehot,
  output logic [IDX_W-1:0]     index
);

  always_comb begin
    onehot = mask & (~mask + NUM_FLITS'(1));
    index  = '0;
    for (int i = NUM_FLITS - 1; i >= 0; i--) begin
      if (mask[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/fabric_out_flit_unpacker.sv
// Serialises the valid lanes of a wide TDM word into a one-flit-per-cycle stream and checks packet framing.
// Optional statistics counters are enabled with FLIT_UNPACK_STATS_EN.
module fabric_out_flit_unpacker
  import fabric_out_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 8,
  parameter int unsigned NUM_FLITS  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_FLITS*FLIT_WIDTH-1:0] i_data_in,
  input  logic                            i_valid_in,
  output logic                            i_ready_out,
  output logic [FLIT_WIDTH-4:0]           o_data_out,
  output logic                            o_head_out,
  output logic                            o_tail_out,
  output logic                            o_valid_out,
  input  logic                            o_ready_in,
  output logic                            o_error_out
`ifdef FLIT_UNPACK_STATS_EN
  ,
  output logic [31:0]                     o_pkt_count_out,
  output logic [31:0]                     o_drop_lane_count_out
`endif
);

  localparam int unsigned PAY_W  = FLIT_WIDTH - LANE_CTRL_BITS;
  localparam int unsigned WORD_W = NUM_FLITS * FLIT_WIDTH;
  localparam int unsigned IDX_W  = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;

  logic [WORD_W-1:0]     word_q;
  logic [NUM_FLITS-1:0]  mask_q;
  logic [NUM_FLITS-1:0]  in_mask;
  logic [NUM_FLITS-1:0]  sel_onehot;
  logic [IDX_W-1:0]      sel_idx;
  logic [FLIT_WIDTH-1:0] sel_lane;
  flit_t                 cur_flit;
  frame_state_t          state_q;
  logic                  error_q;
  logic                  flit_fire;
  logic                  last_flit;
  logic                  accept;
  logic                  unused_flit_bits;

  always_comb begin
    in_mask = '0;
    for (int k = 0; k < NUM_FLITS; k++) begin
      in_mask[k] = i_data_in[k*FLIT_WIDTH + FLIT_WIDTH - LANE_VALID_BIT];
    end
  end

  fabric_out_lane_select #(
    .NUM_FLITS (NUM_FLITS),
    .IDX_W     (IDX_W)
  ) u_lane_select (
    .mask   (mask_q),
    .onehot (sel_onehot),
    .index  (sel_idx)
  );

  always_comb begin
    sel_lane         = word_q[sel_idx*FLIT_WIDTH +: FLIT_WIDTH];
    cur_flit.payload = FLIT_PAYLOAD_MAX_W'(sel_lane[PAY_W-1:0]);
    cur_flit.head    = sel_lane[FLIT_WIDTH-LANE_HEAD_BIT];
    cur_flit.tail    = sel_lane[FLIT_WIDTH-LANE_TAIL_BIT];
  end

  // Lane valid bit is already captured in the mask; payload is zero-extended into the record.
  assign unused_flit_bits = ^{sel_lane[FLIT_WIDTH-LANE_VALID_BIT], cur_flit.payload};

  assign o_data_out  = cur_flit.payload[PAY_W-1:0];
  assign o_head_out  = cur_flit.head;
  assign o_tail_out  = cur_flit.tail;
  assign o_valid_out = |mask_q;
  assign o_error_out = error_q;

  assign flit_fire   = o_valid_out & o_ready_in;
  assign last_flit   = (mask_q == sel_onehot);
  // Ready early on the last flit's handshake so words stream without a bubble.
  assign i_ready_out = ~o_valid_out | (flit_fire & last_flit);
  assign accept      = i_valid_in & i_ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      mask_q  <= '0;
      state_q <= IDLE;
      error_q <= 1'b0;
    end else begin
      if (accept) begin
        word_q <= i_data_in;
        mask_q <= in_mask;
      end else if (flit_fire) begin
        mask_q <= mask_q & ~sel_onehot;
      end

      if (flit_fire) begin
        case (state_q)
          IDLE: begin
            if (!cur_flit.head)      error_q <= 1'b1;
            else if (!cur_flit.tail) state_q <= BODY;
          end
          BODY: begin
            // A head mid-packet is an error but also restarts the packet.
            if (cur_flit.head) error_q <= 1'b1;
            if (cur_flit.tail) state_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef FLIT_UNPACK_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (flit_fire && cur_flit.tail) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (accept) drop_cnt_q <= drop_cnt_q + 32'($countones(~in_mask));
    end
  end

  assign o_pkt_count_out       = pkt_cnt_q;
  assign o_drop_lane_count_out = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fabric_out_flit_unpacker.sv
// Directed bench for fabric_out_flit_unpacker: per-cycle vector table plus reset/framing sequences.
module tb_fabric_out_flit_unpacker;

  localparam int unsigned FW = 8;
  localparam int unsigned NF = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NF*FW-1:0] i_data_in;
  logic            i_valid_in;
  logic            i_ready_out;
  logic [FW-4:0]   o_data_out;
  logic            o_head_out;
  logic            o_tail_out;
  logic            o_valid_out;
  logic            o_ready_in;
  logic            o_error_out;
`ifdef FLIT_UNPACK_STATS_EN
  logic [31:0]     o_pkt_count_out;
  logic [31:0]     o_drop_lane_count_out;
`endif

  fabric_out_flit_unpacker #(
    .FLIT_WIDTH (FW),
    .NUM_FLITS  (NF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data_in   (i_data_in),
    .i_valid_in  (i_valid_in),
    .i_ready_out (i_ready_out),
    .o_data_out  (o_data_out),
    .o_head_out  (o_head_out),
    .o_tail_out  (o_tail_out),
    .o_valid_out (o_valid_out),
    .o_ready_in  (o_ready_in),
    .o_error_out (o_error_out)
`ifdef FLIT_UNPACK_STATS_EN
    ,
    .o_pkt_count_out       (o_pkt_count_out),
    .o_drop_lane_count_out (o_drop_lane_count_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        vin;
    logic        rdy;
    logic        e_valid;
    logic [4:0]  e_data;
    logic        e_head;
    logic        e_tail;
    logic        e_ready;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Lanes are bytes {v,h,t,payload[4:0]}; word = {lane3,lane2,lane1,lane0}
  localparam logic [31:0] W1 = 32'hA4_83_82_C1;  // head 01, body 02, body 03, tail 04
  localparam logic [31:0] W2 = 32'hEB_00_EA_00;  // lanes 1,3 single-flit 0A,0B
  localparam logic [31:0] W0 = 32'h00_00_00_00;  // all lanes invalid
  localparam logic [31:0] W5 = 32'hB4_D3_D2_91;  // body 11 (err), head 12, head 13 (err), tail 14

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] data, input logic vin, input logic rdy,
                     input logic ev, input logic [4:0] ed, input logic eh, input logic et,
                     input logic er, input logic ee);
    vec_t v;
    v.data = data; v.vin = vin; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_head = eh; v.e_tail = et;
    v.e_ready = er; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] data, input logic vin, input logic rdy);
    @(negedge clk);
    i_data_in  = data;
    i_valid_in = vin;
    o_ready_in = rdy;
    #1;
  endtask

  task automatic check_flit(input string name, input logic [4:0] d, input logic h, input logic t);
    check({name, "_valid"}, 32'(o_valid_out), 32'd1);
    check({name, "_data"},  32'(o_data_out),  32'(d));
    check({name, "_head"},  32'(o_head_out),  32'(h));
    check({name, "_tail"},  32'(o_tail_out),  32'(t));
  endtask

  initial begin
    //   data vin rdy | valid data head tail ready err
    add(W1, 1, 1,  0, 5'h00, 0, 0, 1, 0);  // accept 4-flit packet
    add(W0, 0, 1,  1, 5'h01, 1, 0, 0, 0);
    add(W0, 0, 1,  1, 5'h02, 0, 0, 0, 0);
    add(W0, 0, 1,  1, 5'h03, 0, 0, 0, 0);
    add(W2, 1, 1,  1, 5'h04, 0, 1, 1, 0);  // last flit + next word accepted
    add(W0, 0, 1,  1, 5'h0A, 1, 1, 0, 0);  // empty lane 0 skipped
    add(W0, 1, 1,  1, 5'h0B, 1, 1, 1, 0);  // all-invalid word accepted here
    add(W1, 1, 1,  0, 5'h00, 0, 0, 1, 0);  // no output from empty word
    add(W0, 0, 1,  1, 5'h01, 1, 0, 0, 0);
    add(W0, 0, 0,  1, 5'h02, 0, 0, 0, 0);  // backpressure x3
    add(W0, 0, 0,  1, 5'h02, 0, 0, 0, 0);
    add(W0, 0, 0,  1, 5'h02, 0, 0, 0, 0);
    add(W0, 0, 1,  1, 5'h02, 0, 0, 0, 0);
    add(W0, 0, 1,  1, 5'h03, 0, 0, 0, 0);
    add(W0, 0, 1,  1, 5'h04, 0, 1, 1, 0);
    add(W5, 1, 1,  0, 5'h00, 0, 0, 1, 0);  // framing-violation word
    add(W0, 0, 1,  1, 5'h11, 0, 0, 0, 0);
    add(W0, 0, 1,  1, 5'h12, 1, 0, 0, 1);
    add(W0, 0, 1,  1, 5'h13, 1, 0, 0, 1);
    add(W0, 0, 1,  1, 5'h14, 0, 1, 1, 1);
    add(W0, 0, 1,  0, 5'h00, 0, 0, 1, 1);  // error stays sticky

    rst = 1'b1; i_data_in = '0; i_valid_in = 1'b0; o_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(o_valid_out), 32'd0);
    check("rst_ready", 32'(i_ready_out), 32'd1);
    check("rst_err",   32'(o_error_out), 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].data, vecs[i].vin, vecs[i].rdy);
      check($sformatf("v%0d_valid", i), 32'(o_valid_out), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_ready", i), 32'(i_ready_out), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_err",   i), 32'(o_error_out), 32'(vecs[i].e_err));
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_data", i), 32'(o_data_out), 32'(vecs[i].e_data));
        check($sformatf("v%0d_head", i), 32'(o_head_out), 32'(vecs[i].e_head));
        check($sformatf("v%0d_tail", i), 32'(o_tail_out), 32'(vecs[i].e_tail));
      end
    end

`ifdef FLIT_UNPACK_STATS_EN
    // Tails: 04, 0A, 0B, 04, 14; invalid lanes: 0 + 2 + 4 + 0 + 0
    check("stat_pkt",  o_pkt_count_out,       32'd5);
    check("stat_drop", o_drop_lane_count_out, 32'd6);
`endif

    // Reset clears the sticky error flag
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("rst2_err",   32'(o_error_out), 32'd0);
    check("rst2_valid", 32'(o_valid_out), 32'd0);

    // Reset mid-packet with two flits pending
    drive(W1, 1'b1, 1'b1);
    drive(W0, 1'b0, 1'b1);
    check_flit("mid_f0", 5'h01, 1'b1, 1'b0);
    drive(W0, 1'b0, 1'b1);
    check_flit("mid_f1", 5'h02, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("mid_rst_valid", 32'(o_valid_out), 32'd0);
    check("mid_rst_ready", 32'(i_ready_out), 32'd1);
`ifdef FLIT_UNPACK_STATS_EN
    check("mid_rst_pkt",  o_pkt_count_out,       32'd0);
    check("mid_rst_drop", o_drop_lane_count_out, 32'd0);
`endif
    drive(W0, 1'b0, 1'b1);
    check("mid_idle_valid", 32'(o_valid_out), 32'd0);

    // Fresh word: head must start a packet cleanly after reset left the FSM mid-packet
    drive(W1, 1'b1, 1'b1);
    check("fresh_accept_ready", 32'(i_ready_out), 32'd1);
    drive(W0, 1'b0, 1'b1);
    check_flit("fresh_f0", 5'h01, 1'b1, 1'b0);
    drive(W0, 1'b0, 1'b1);
    check_flit("fresh_f1", 5'h02, 1'b0, 1'b0);
    check("fresh_err1", 32'(o_error_out), 32'd0);
    drive(W0, 1'b0, 1'b1);
    check_flit("fresh_f2", 5'h03, 1'b0, 1'b0);
    drive(W0, 1'b0, 1'b1);
    check_flit("fresh_f3", 5'h04, 1'b0, 1'b1);
    drive(W0, 1'b0, 1'b1);
    check("fresh_done_valid", 32'(o_valid_out), 32'd0);
    check("fresh_err2",       32'(o_error_out), 32'd0);
`ifdef FLIT_UNPACK_STATS_EN
    check("fresh_pkt",  o_pkt_count_out,       32'd1);
    check("fresh_drop", o_drop_lane_count_out, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fabric_out_flit_unpacker.md
Name: fabric_out_flit_unpacker

Overview:
- Sits on the module-side (slow) clock directly downstream of the fabric-port-out demux.
- Consumes the demux's wide TDM word, which carries NUM_FLITS flit lanes, and serialises the valid lanes into a one-flit-per-cycle stream for the attached module.
- Drops empty lanes without spending a cycle on them.
- Runs a packet-framing FSM that tracks head and tail markers and flags framing violations.

Parameters:
- FLIT_WIDTH, 8: width of one lane. Bit FLIT_WIDTH-1 is valid, bit FLIT_WIDTH-2 is head, bit FLIT_WIDTH-3 is tail, and the low FLIT_WIDTH-3 bits are payload.
- NUM_FLITS, 4: number of lanes per wide word. Lane k is i_data_in[k*FLIT_WIDTH +: FLIT_WIDTH]; lane 0 is the oldest.

Ports:
- clk, in, 1: single clock (module/rtl clock).
- rst, in, 1: synchronous reset, active-high.
- i_data_in, in, NUM_FLITS*FLIT_WIDTH: wide word from the demux.
- i_valid_in, in, 1: wide word valid.
- i_ready_out, out, 1: unpacker can accept a word; drives the demux o_ready_in.
- o_data_out, out, FLIT_WIDTH-3: flit payload.
- o_head_out, out, 1: flit is a packet head.
- o_tail_out, out, 1: flit is a packet tail.
- o_valid_out, out, 1: flit valid.
- o_ready_in, in, 1: downstream accepts the flit.
- o_error_out, out, 1: sticky framing-error flag.

Behaviour:
- Storage:
  - One holding register: the word, plus a NUM_FLITS-bit pending mask loaded from the lane valid bits.
  - The holding register is empty when the mask is 0.
- Reset (synchronous):
  - Mask cleared; FSM goes to IDLE; o_error_out=0.
  - Consequently o_valid_out=0 and i_ready_out=1 in the first cycle after reset.
  - Reset asserted mid-packet discards the held word and any partial packet.
- Accept:
  - A word is taken on a cycle with i_valid_in & i_ready_out.
  - i_ready_out = (mask==0) | (o_valid_out & o_ready_in & exactly one mask bit set).
  - This gives back-to-back words with no bubble.
- Emit:
  - o_valid_out = (mask!=0).
  - The lane presented is the lowest set mask bit (priority encode); o_data_out, o_head_out and o_tail_out come from that lane combinationally.
  - On o_valid_out & o_ready_in, that mask bit is cleared.
  - Latency: the first flit is visible the cycle after acceptance.
  - A word with n valid lanes drains in n cycles when o_ready_in=1.
- All-invalid word: accepted; the mask loads 0; it produces no output and no FSM effect.
- Backpressure: while o_ready_in=0, the mask and the presented flit are held stable and i_ready_out=0, unless the mask is already 0.
- Framing FSM, which advances only on a flit handshake:
  - IDLE:
    - head & tail goes to IDLE (single-flit packet).
    - head & ~tail goes to BODY.
    - ~head sets o_error_out and stays in IDLE.
  - BODY:
    - ~head & tail goes to IDLE.
    - ~head & ~tail stays in BODY.
    - head sets o_error_out and restarts: goes to IDLE if tail is also set, otherwise stays in BODY.
  - Errored flits are still forwarded unchanged.
  - o_error_out clears only on rst.
- Simultaneous events: a last-flit handshake and a new-word accept in the same cycle load the new mask. The FSM update for the departing flit still applies.

Optional Feature:
- FLIT_UNPACK_STATS_EN defined:
  - Adds output o_pkt_count_out (32 bits), which counts handshakes with tail set.
  - Adds output o_drop_lane_count_out (32 bits), which counts invalid lanes in accepted words.
  - Both counters wrap at 2^32 and clear on rst.
- Undefined: neither port nor either counter exists. Core behaviour is identical.

Decomposition:
- Shared package fabric_out_pkg holds:
  - The lane bit-position localparams (LANE_VALID_BIT, LANE_HEAD_BIT, LANE_TAIL_BIT, as offsets from FLIT_WIDTH).
  - The framing FSM enum typedef with IDLE and BODY.
  - A flit struct typedef holding payload, head and tail.
- One sub-module: fabric_out_lane_select. It takes a NUM_FLITS mask and produces a one-hot lowest-set-bit plus a binary index. It is purely combinational and parameterised on NUM_FLITS.

Test Plan (FLIT_WIDTH=8, NUM_FLITS=4; each lane is written as v,h,t,payload):
1. Word with lanes {1,1,0,5'h01}, {1,0,0,5'h02}, {1,0,0,5'h03}, {1,0,1,5'h04} and o_ready_in=1 -> payloads 01,02,03,04 on 4 consecutive cycles; head on the first, tail on the last; o_error_out=0; i_ready_out=1 during the 4th cycle.
2. Lanes 1 and 3 valid (single-flit packets h=t=1, payloads 0A and 0B), lanes 0 and 2 invalid -> exactly 2 output cycles, 0A then 0B; no bubbles.
3. All-invalid word followed immediately by a valid word -> first word produces no output; second word's first flit appears the cycle after its acceptance.
4. o_ready_in=0 for 3 cycles in the middle of a 4-flit word -> o_data_out held stable; i_ready_out=0; no flit lost or duplicated; order 01..04 preserved.
5. Body flit (h=0) while the FSM is in IDLE, then a head while in BODY -> o_error_out rises on the first violation and stays 1; all flits are forwarded; rst clears the flag.
6. rst asserted with 2 flits pending, then a fresh word sent -> pending flits never appear; the new word's first flit is treated as a packet start with no error. With FLIT_UNPACK_STATS_EN defined, both counters read 0 after rst.
